// File: rtl/datapath_seq_pkg.sv
// Shared opcode, sequencer-state and ALU-select encodings for the datapath_seq slice.
package datapath_seq_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_EXEC = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_e;

endpackage

// File: rtl/datapath_seq_if.sv
// Command, status and observation bundle between the control unit (master) and datapath_seq (slave).
interface datapath_seq_if #(
  parameter int N    = 8,
  parameter int NREG = 4
);
  localparam int SW = $clog2(NREG);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [SW-1:0] cmd_src;
  logic [SW-1:0] cmd_dst;
  logic [N-1:0]  ld_data;
  logic          done;
  logic [N-1:0]  ac_out;
  logic          flag_z;
  logic          flag_c;
  logic          flag_v;
  logic [SW-1:0] rd_sel;
  logic [N-1:0]  rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, ld_data, rd_sel,
    input  cmd_ready, done, ac_out, flag_z, flag_c, flag_v, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, ld_data, rd_sel,
    output cmd_ready, done, ac_out, flag_z, flag_c, flag_v, rd_data
  );

endinterface

// File: rtl/datapath_seq_alu_flags.sv
// N-bit add / subtract / pass-through of b, with carry-or-borrow and signed overflow.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module alu_flags
  import datapath_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  alu_op_e      op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow
);

  logic [N:0] sum_ext;
  logic [N:0] dif_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  // The extra top bit of the difference is the borrow, i.e. a < b unsigned.
  assign dif_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = b;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum_ext[N-1:0];
        carry    = sum_ext[N];
        overflow = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = dif_ext[N-1:0];
        carry    = dif_ext[N];
        overflow = (a[N-1] != b[N-1]) && (dif_ext[N-1] != a[N-1]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_seq.sv
// Register file + AC/T datapath run by a 3-state micro-sequencer, one command per handshake.
// Latency: accept edge k, T loaded k+1, result and done visible after k+2.
// Backpressure: cmd_ready only in IDLE (including the done cycle); peak one command per 3 cycles.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREG = 4,
  parameter int INIT = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  datapath_seq_if.slave  bus
);

  localparam int SW = $clog2(NREG);
  localparam logic [N-1:0] INIT_V = N'(INIT);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] dst_q, dst_d;
  logic [N-1:0]  ld_q, ld_d;
  logic [N-1:0]  ac_q, ac_d;
  logic [N-1:0]  t_q, t_d;
  logic [N-1:0]  regs_q [NREG];
  logic [N-1:0]  regs_d [NREG];
  logic          z_q, z_d, c_q, c_d, v_q, v_d;
  logic          done_q, done_d;

  alu_op_e       alu_op;
  logic [N-1:0]  alu_res;
  logic          alu_c, alu_v;
  logic          src_ok, dst_ok;

  assign src_ok = int'(src_q) < NREG;
  assign dst_ok = int'(dst_q) < NREG;

  always_comb begin
    alu_op = ALU_PASS;
    if (op_q == OP_ADD) alu_op = ALU_ADD;
    if (op_q == OP_SUB) alu_op = ALU_SUB;
  end

  alu_flags #(.N(N)) u_alu (
    .op       (alu_op),
    .a        (ac_q),
    .b        (t_q),
    .result   (alu_res),
    .carry    (alu_c),
    .overflow (alu_v)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ld_d    = ld_q;
    ac_d    = ac_q;
    t_d     = t_q;
    regs_d  = regs_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          src_d   = bus.cmd_src;
          dst_d   = bus.cmd_dst;
          ld_d    = bus.ld_data;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // Out-of-range source indices read as zero.
        t_d     = src_ok ? regs_q[src_q] : '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        case (op_q)
          OP_LDI: begin
            ac_d = ld_q;
            z_d  = (ld_q == '0);
          end
          OP_LD: begin
            ac_d = t_q;
            z_d  = (t_q == '0);
          end
          OP_ST:  if (dst_ok) regs_d[dst_q] = ac_q;
          OP_ADD, OP_SUB: begin
            ac_d = alu_res;
            z_d  = (alu_res == '0);
            c_d  = alu_c;
            v_d  = alu_v;
          end
          OP_MOV: if (dst_ok) regs_d[dst_q] = t_q;
          OP_CLR: begin
            ac_d = '0;
            z_d  = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      src_q   <= '0;
      dst_q   <= '0;
      ld_q    <= '0;
      ac_q    <= '0;
      t_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= INIT_V;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ld_q    <= ld_d;
      ac_q    <= ac_d;
      t_q     <= t_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.done      = done_q;
  assign bus.ac_out    = ac_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.rd_data   = (int'(bus.rd_sel) < NREG) ? regs_q[bus.rd_sel] : '0;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq (N=8, NREG=4, INIT=10) with hand-computed expectations.
module tb_datapath_seq;
  import datapath_seq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  datapath_seq_if #(.N(8), .NREG(4)) bus ();

  datapath_seq #(.N(8), .NREG(4), .INIT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {Z, C, V}.
  task automatic chk_flags(input string tag, input logic [2:0] zcv);
    chk(tag, {29'd0, bus.flag_z, bus.flag_c, bus.flag_v}, {29'd0, zcv});
  endtask

  task automatic reg_is(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    bus.rd_sel = idx;
    #1;
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  // Counts cycles from the accept edge until done; expects exactly 2.
  task automatic wait_done(input string tag);
    int cyc = 0;
    while (bus.done !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'd2);
    chk({tag, ".ready_at_done"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [7:0] data, input string tag);
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.ld_data   = data;
    bus.cmd_valid = 1'b1;
    chk({tag, ".ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble fields after acceptance; they must not affect the running command.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_CLR;
    bus.cmd_src   = ~src;
    bus.cmd_dst   = ~dst;
    bus.ld_data   = ~data;
    wait_done(tag);
  endtask

  task automatic count_done(input int ncyc, input string tag);
    int pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.ld_data   = '0;
    bus.rd_sel    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) reg_is(2'(i), 8'h0A, "rst.reg");
    chk("rst.ac", 32'(bus.ac_out), 32'h00);
    chk_flags("rst.flags", 3'b000);
    chk("rst.ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst.done", 32'(bus.done), 32'd0);

    run_cmd(OP_LDI, 2'd0, 2'd0, 8'h7F, "ldi7f");
    chk("ldi7f.ac", 32'(bus.ac_out), 32'h7F);
    chk_flags("ldi7f.flags", 3'b000);
    run_cmd(OP_ADD, 2'd0, 2'd0, 8'h00, "add_ovf");
    chk("add_ovf.ac", 32'(bus.ac_out), 32'h89);
    chk_flags("add_ovf.flags", 3'b001);

    run_cmd(OP_LDI, 2'd0, 2'd0, 8'h05, "ldi05");
    run_cmd(OP_SUB, 2'd1, 2'd0, 8'h00, "sub_brw");
    chk("sub_brw.ac", 32'(bus.ac_out), 32'hFB);
    chk_flags("sub_brw.flags", 3'b010);
    run_cmd(OP_ST, 2'd0, 2'd2, 8'h00, "st2");
    reg_is(2'd2, 8'hFB, "st2.r2");
    chk_flags("st2.flags", 3'b010);

    run_cmd(OP_LD, 2'd2, 2'd0, 8'h00, "ld2");
    chk("ld2.ac", 32'(bus.ac_out), 32'hFB);
    chk_flags("ld2.flags", 3'b010);
    run_cmd(OP_MOV, 2'd1, 2'd1, 8'h00, "mov_same");
    reg_is(2'd1, 8'h0A, "mov_same.r1");
    run_cmd(OP_CLR, 2'd0, 2'd0, 8'h00, "clr");
    chk("clr.ac", 32'(bus.ac_out), 32'h00);
    chk_flags("clr.flags", 3'b110);

    run_cmd(OP_LDI, 2'd0, 2'd0, 8'hF6, "ldif6");
    chk_flags("ldif6.flags", 3'b010);
    run_cmd(OP_ADD, 2'd0, 2'd0, 8'h00, "add_wrap");
    chk("add_wrap.ac", 32'(bus.ac_out), 32'h00);
    chk_flags("add_wrap.flags", 3'b110);

    // NOP in flight, then MOV held valid while busy.
    @(negedge clk);
    bus.cmd_op = OP_NOP; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_op = OP_MOV; bus.cmd_src = 2'd2; bus.cmd_dst = 2'd3;
    chk("hold.xfer_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold.exec_ready", 32'(bus.cmd_ready), 32'd0);
    chk("hold.exec_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    chk("hold.nop_done", 32'(bus.done), 32'd1);
    chk("hold.nop_ready", 32'(bus.cmd_ready), 32'd1);
    chk_flags("hold.nop_flags", 3'b110);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("hold.mov_accepted", 32'(bus.cmd_ready), 32'd0);
    wait_done("hold.mov");
    reg_is(2'd3, 8'hFB, "hold.r3");
    count_done(4, "hold.no_dup");
    reg_is(2'd3, 8'hFB, "hold.r3_after");
    chk("hold.ac", 32'(bus.ac_out), 32'h00);

    // Reset during XFER of ST dst=1.
    run_cmd(OP_LDI, 2'd0, 2'd0, 8'h33, "ldi33");
    chk("ldi33.ac", 32'(bus.ac_out), 32'h33);
    @(negedge clk);
    bus.cmd_op = OP_ST; bus.cmd_dst = 2'd1; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("rstmid.in_xfer", 32'(bus.cmd_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.ready", 32'(bus.cmd_ready), 32'd1);
    chk("rstmid.ac", 32'(bus.ac_out), 32'h00);
    chk_flags("rstmid.flags", 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(5, "rstmid.no_done");
    reg_is(2'd1, 8'h0A, "rstmid.r1");
    reg_is(2'd2, 8'h0A, "rstmid.r2");
    chk("rstmid.ac_after", 32'(bus.ac_out), 32'h00);
    chk("rstmid.ready_after", 32'(bus.cmd_ready), 32'd1);

    run_cmd(OP_LDI, 2'd0, 2'd0, 8'h01, "post.ldi");
    run_cmd(OP_ADD, 2'd3, 2'd0, 8'h00, "post.add");
    chk("post.ac", 32'(bus.ac_out), 32'h0B);
    chk_flags("post.flags", 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor to the shared-bus data unit: NREG general registers, accumulator AC, temp T and ALU, now driven by an internal micro-sequencer instead of raw per-register R/W strobes.
- Accepts one command per valid/ready handshake, executes it in a fixed 3-cycle micro-sequence, and reports completion and status flags.
- Sits below the control unit, which issues opcode, register indices and immediate data.

Parameters:
- N, 8, data width of registers, AC, T, buses; N >= 2.
- NREG, 4, number of general registers; NREG >= 2.
- INIT, 10, reset value loaded into every general register.
- SW, $clog2(NREG), derived register-index width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  opcode.
- cmd_src  input  SW  source register index.
- cmd_dst  input  SW  destination register index.
- ld_data  input  N  immediate operand for LDI.
- done  output  1  one-cycle completion pulse.
- ac_out  output  N  current AC value.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry / borrow flag.
- flag_v  output  1  signed overflow flag.
- rd_sel  input  SW  observation read index.
- rd_data  output  N  combinational R[rd_sel]; 0 if rd_sel >= NREG.

Behaviour:
- Reset (async, rst_n=0):
  - R[i]=INIT; AC=0, T=0; flags 0; done=0; state IDLE; cmd_ready=1.
  - Reset mid-operation abandons the command with no register, AC or flag write.
- Opcodes:
  - 000 NOP.
  - 001 LDI: AC<=ld_data.
  - 010 LD: AC<=R[src].
  - 011 ST: R[dst]<=AC.
  - 100 ADD: AC<=AC+R[src].
  - 101 SUB: AC<=AC-R[src].
  - 110 MOV: R[dst]<=R[src], routed through T.
  - 111 CLR: AC<=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, capture op/src/dst/ld_data, go to XFER. cmd_valid without acceptance has no effect.
  - XFER: T<=R[src], for every op. Go to EXEC.
  - EXEC: commit the result, set done=1 on the same edge, go to IDLE.
- Latency and throughput:
  - Accept edge k, T loaded edge k+1, result and done visible after edge k+2.
  - cmd_ready=1 in the same cycle done=1, so a new command is accepted on that cycle's edge. Peak rate is one command per 3 cycles.
  - Command fields are sampled only at acceptance; later changes are ignored.
- Arithmetic (all N-bit, wrap modulo 2^N):
  - ADD: C = carry out of bit N-1.
  - SUB: C = borrow, i.e. 1 when AC < R[src] unsigned.
  - V = two's-complement signed overflow for ADD and SUB.
- Flag update rules:
  - Z = (new AC == 0); updated by LDI, LD, ADD, SUB, CLR.
  - C and V are updated only by ADD/SUB; they hold on all other ops.
  - NOP, ST, MOV hold all flags.
- Index boundaries:
  - src >= NREG reads 0.
  - dst >= NREG suppresses the write.
  - MOV with src==dst leaves the register unchanged.
- ST/MOV writes are visible on rd_data in the cycle after EXEC's edge.

Decomposition:
- Package datapath_seq_pkg holds:
  - opcode localparams (OP_NOP..OP_CLR);
  - state encoding (S_IDLE, S_XFER, S_EXEC).
- One sub-module, alu_flags #(N):
  - inputs: op select, a, b;
  - outputs: result, carry, overflow;
  - purely combinational, ADD/SUB/pass-through.

Test Plan (N=8, NREG=4, INIT=10):
- Reset released: R0..R3=0x0A, AC=0, flags 000, cmd_ready=1, done=0.
- LDI 0x7F, then ADD src=0: AC=0x89, V=1, C=0, Z=0; done high exactly 2 cycles after each accept cycle.
- LDI 0x05, SUB src=1, then ST dst=2: AC=0xFB, C=1, V=0; rd_sel=2 returns 0xFB; ST leaves flags unchanged.
- LDI 0xF6, ADD src=0: AC=0x00, Z=1, C=1, V=0.
- cmd_valid held high with MOV src=2 dst=3 while busy: accepted only in the done=1 cycle; R3=0xFB afterwards; no duplicate execution.
- rst_n pulsed low during XFER of ST dst=1 (AC=0x33): R1 stays 0x0A, AC=0, done never pulses, state IDLE.
